wb_commit_queue: RTL and testbench

//  Write-back stage in front of the register file's single write port. Merges single-cycle
//  ALU results with out-of-order long-latency results (load/mul) queued in a small FIFO,
//  and keeps a pending-register scoreboard so decode stalls on RAW/WAW hazards.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 51 +++++
 rtl/wb_commit_queue.sv | 122 ++++++++++++
 tb/tb_wb_commit_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back commit queue.
// Defines the FIFO entry layout, the x0 register address and a constant clog2 helper.
package wb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  localparam logic [WB_AW-1:0] RV_X0 = 5'd0;

  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  function automatic int wb_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO holding long-latency results until the write port is free.
// Pushes into a full FIFO and pops from an empty one are ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  localparam int PW      = wb_clog2(DEPTH),
  localparam int CW      = wb_clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  output entry_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Write-back arbiter and pending-register scoreboard in front of the register file write port.
// Optional macro WB_FWD_EN forwards the value being committed to decode queries in the commit cycle.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  AW    = WB_AW,
  parameter int  DW    = WB_DW,
  localparam int CW    = wb_clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic          lat_valid,
  input  logic [AW-1:0] lat_rd,
  input  logic [DW-1:0] lat_data,
  output logic          lat_ready,
  input  logic          alu_we,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] q_rs1,
  input  logic [AW-1:0] q_rs2,
  input  logic [AW-1:0] q_rd,
  output logic          stall,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data,
  output logic [CW-1:0] count
);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  logic            full;
  logic            empty;
  logic            push;
  logic            alu_win;
  logic            fifo_commit;
  entry_t          lat_entry;
  entry_t          head;
  logic [2**AW-1:0] pend;
  logic [2**AW-1:0] pend_next;
  logic            hit1;
  logic            hit2;
  logic            hit3;

  assign alu_win     = alu_we && (alu_rd != AW'(RV_X0));
  assign lat_ready   = !full;
  // x0 results are handshaken but never stored, so they can never reach the port.
  assign push        = lat_valid && !full && (lat_rd != AW'(RV_X0));
  assign fifo_commit = !alu_win && !empty;
  assign lat_entry   = '{rd: lat_rd, data: lat_data};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .wdata (lat_entry),
    .pop   (fifo_commit),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (alu_win) begin
      rf_we    = 1'b1;
      rf_waddr = alu_rd;
      rf_wdata = alu_data;
    end else if (!empty) begin
      rf_we    = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

  // A new issue to the register being retired this cycle must stay pending.
  always_comb begin
    pend_next = pend;
    if (fifo_commit) pend_next[head.rd] = 1'b0;
    if (iss_valid && (iss_rd != AW'(RV_X0))) pend_next[iss_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= pend_next;
  end

`ifdef WB_FWD_EN
  assign hit1     = rf_we && (rf_waddr != AW'(RV_X0)) && (q_rs1 == rf_waddr);
  assign hit2     = rf_we && (rf_waddr != AW'(RV_X0)) && (q_rs2 == rf_waddr);
  assign hit3     = rf_we && (rf_waddr != AW'(RV_X0)) && (q_rd  == rf_waddr);
  assign fwd_data = rf_wdata;
`else
  assign hit1     = 1'b0;
  assign hit2     = 1'b0;
  assign hit3     = 1'b0;
  assign fwd_data = '0;
`endif

  assign fwd_hit1 = hit1;
  assign fwd_hit2 = hit2;

  // Without forwarding the register file still returns the old value during the commit cycle.
  assign stall = (pend[q_rs1] && !hit1) || (pend[q_rs2] && !hit2) ||
                 (pend[q_rd] && !hit3) || (count == CW'(DEPTH));

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed self-checking bench for wb_commit_queue; adapts its expectations when WB_FWD_EN is defined.
`timescale 1ns/1ps
module tb_wb_commit_queue;

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        lat_valid;
  logic [4:0]  lat_rd;
  logic [31:0] lat_data;
  logic        lat_ready;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic [4:0]  q_rd;
  logic        stall;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int passed;
  int total;

  wb_commit_queue dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .lat_valid (lat_valid),
    .lat_rd    (lat_rd),
    .lat_data  (lat_data),
    .lat_ready (lat_ready),
    .alu_we    (alu_we),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_rd      (q_rd),
    .stall     (stall),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    iss_valid = 1'b0; iss_rd = '0;
    lat_valid = 1'b0; lat_rd = '0; lat_data = '0;
    alu_we = 1'b0; alu_rd = '0; alu_data = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
    #2;
    total++; if (count !== 3'd0) $display("[TB] FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (lat_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %0b want 1", lat_ready); else passed++;
    total++; if (rf_we !== 1'b0) $display("[TB] FAIL reset_we: got %0b want 0", rf_we); else passed++;
    total++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %0b want 0", stall); else passed++;
    total++; if ({fwd_hit1, fwd_hit2} !== 2'b00) $display("[TB] FAIL reset_fwd: got %b want 00", {fwd_hit1, fwd_hit2}); else passed++;
    #10;
    rst = 1'b1;
  endtask

  task automatic test_issue_commit();
    tick();
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0; q_rs1 = 5'd5;
    #1;
    total++; if (stall !== 1'b1) $display("[TB] FAIL t1_pend_stall: got %0b want 1", stall); else passed++;
    tick();
    tick();
    lat_valid = 1'b1; lat_rd = 5'd5; lat_data = 32'h1234;
    #1;
    total++; if (rf_we !== 1'b0) $display("[TB] FAIL t1_no_passthru: got %0b want 0", rf_we); else passed++;
    tick();
    lat_valid = 1'b0;
    #1;
    total++; if (rf_we !== 1'b1) $display("[TB] FAIL t1_we: got %0b want 1", rf_we); else passed++;
    total++; if (rf_waddr !== 5'd5) $display("[TB] FAIL t1_addr: got %0d want 5", rf_waddr); else passed++;
    total++; if (rf_wdata !== 32'h1234) $display("[TB] FAIL t1_data: got %h want 00001234", rf_wdata); else passed++;
    total++; if (stall !== !FWD) $display("[TB] FAIL t1_commit_stall: got %0b want %0b", stall, !FWD); else passed++;
    total++; if (fwd_hit1 !== FWD) $display("[TB] FAIL t1_fwd_hit1: got %0b want %0b", fwd_hit1, FWD); else passed++;
    tick();
    total++; if (stall !== 1'b0) $display("[TB] FAIL t1_stall_drop: got %0b want 0", stall); else passed++;
    total++; if (count !== 3'd0) $display("[TB] FAIL t1_count: got %0d want 0", count); else passed++;
    q_rs1 = '0;
  endtask

  task automatic test_alu_priority();
    alu_we = 1'b1; alu_rd = 5'd7; alu_data = 32'd9;
    lat_valid = 1'b1; lat_rd = 5'd8; lat_data = 32'd1;
    #1;
    total++; if (rf_waddr !== 5'd7 || rf_wdata !== 32'd9) $display("[TB] FAIL t2_c1: got x%0d=%0d want x7=9", rf_waddr, rf_wdata); else passed++;
    tick();
    lat_valid = 1'b0;
    #1;
    total++; if (rf_waddr !== 5'd7 || count !== 3'd1) $display("[TB] FAIL t2_c2: got x%0d cnt %0d want x7 cnt 1", rf_waddr, count); else passed++;
    tick();
    total++; if (rf_waddr !== 5'd7 || rf_we !== 1'b1) $display("[TB] FAIL t2_c3: got x%0d we %0b want x7 we 1", rf_waddr, rf_we); else passed++;
    tick();
    alu_we = 1'b0;
    #1;
    total++; if (rf_waddr !== 5'd8 || rf_wdata !== 32'd1 || rf_we !== 1'b1) $display("[TB] FAIL t2_c4: got x%0d=%0d want x8=1", rf_waddr, rf_wdata); else passed++;
    tick();
    total++; if (count !== 3'd0 || rf_we !== 1'b0) $display("[TB] FAIL t2_drain: got cnt %0d we %0b want 0 0", count, rf_we); else passed++;
  endtask

  task automatic test_full();
    alu_we = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      lat_valid = 1'b1; lat_rd = 5'(10 + i); lat_data = 32'h100 + 32'(i);
      tick();
    end
    lat_valid = 1'b1; lat_rd = 5'd14; lat_data = 32'hDEAD;
    #1;
    total++; if (count !== 3'd4) $display("[TB] FAIL t3_count: got %0d want 4", count); else passed++;
    total++; if (lat_ready !== 1'b0) $display("[TB] FAIL t3_ready: got %0b want 0", lat_ready); else passed++;
    total++; if (stall !== 1'b1) $display("[TB] FAIL t3_stall: got %0b want 1", stall); else passed++;
    total++; if (rf_waddr !== 5'd9) $display("[TB] FAIL t3_alu_wins: got x%0d want x9", rf_waddr); else passed++;
    tick();
    lat_valid = 1'b0; alu_we = 1'b0;
    #1;
    total++; if (count !== 3'd4) $display("[TB] FAIL t3_fifth_rejected: got %0d want 4", count); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rf_waddr !== 5'(10 + i) || rf_wdata !== 32'h100 + 32'(i))
        $display("[TB] FAIL t3_drain%0d: got x%0d=%h want x%0d=%h", i, rf_waddr, rf_wdata, 10 + i, 32'h100 + 32'(i));
      else passed++;
      tick();
    end
    total++; if (count !== 3'd0 || rf_we !== 1'b0) $display("[TB] FAIL t3_empty: got cnt %0d we %0b want 0 0", count, rf_we); else passed++;
  endtask

  task automatic test_x0();
    lat_valid = 1'b1; lat_rd = 5'd0; lat_data = 32'hFFFF;
    #1;
    total++; if (lat_ready !== 1'b1) $display("[TB] FAIL t4_ready: got %0b want 1", lat_ready); else passed++;
    tick();
    lat_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (rf_we !== 1'b0 || count !== 3'd0) $display("[TB] FAIL t4_dropped%0d: got we %0b cnt %0d want 0 0", i, rf_we, count);
      else passed++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) begin
      iss_valid = 1'b1; iss_rd = 5'(i);
      lat_valid = 1'b1; lat_rd = 5'(i); lat_data = 32'(i);
      alu_we = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
      tick();
    end
    iss_valid = 1'b0; lat_valid = 1'b0; q_rs1 = 5'd2;
    #1;
    total++; if (count !== 3'd3 || stall !== 1'b1) $display("[TB] FAIL t5_pre: got cnt %0d stall %0b want 3 1", count, stall); else passed++;
    alu_we = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (count !== 3'd0) $display("[TB] FAIL t5_count: got %0d want 0", count); else passed++;
    total++; if (rf_we !== 1'b0) $display("[TB] FAIL t5_we: got %0b want 0", rf_we); else passed++;
    total++; if (stall !== 1'b0) $display("[TB] FAIL t5_stall: got %0b want 0", stall); else passed++;
    #2;
    rst = 1'b1;
    q_rs1 = '0;
  endtask

  task automatic test_forward();
    tick();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0;
    lat_valid = 1'b1; lat_rd = 5'd4; lat_data = 32'hAB;
    q_rs2 = 5'd4;
    #1;
    total++; if (stall !== 1'b1) $display("[TB] FAIL t6_pre_stall: got %0b want 1", stall); else passed++;
    tick();
    lat_valid = 1'b0;
    #1;
    total++; if (stall !== !FWD) $display("[TB] FAIL t6_stall: got %0b want %0b", stall, !FWD); else passed++;
    total++; if (fwd_hit2 !== FWD) $display("[TB] FAIL t6_hit2: got %0b want %0b", fwd_hit2, FWD); else passed++;
    total++; if (fwd_hit1 !== 1'b0) $display("[TB] FAIL t6_hit1: got %0b want 0", fwd_hit1); else passed++;
    total++; if (fwd_data !== (FWD ? 32'hAB : 32'h0)) $display("[TB] FAIL t6_data: got %h want %h", fwd_data, FWD ? 32'hAB : 32'h0); else passed++;
    tick();
    total++; if (stall !== 1'b0) $display("[TB] FAIL t6_after: got %0b want 0", stall); else passed++;
    q_rs2 = '0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_issue_commit();
    test_alu_priority();
    test_full();
    test_x0();
    test_async_reset();
    test_forward();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
